// File: rtl/apu_frame_sequencer.sv
// APU frame sequencer: quarter/half-frame clock pulses, frame IRQ and the
// delayed $4017 counter reset, with selectable NTSC/PAL step tables.
module apu_frame_sequencer #(
  parameter int CNT_W = 16,
  parameter logic [5*CNT_W-1:0] STEPS_NTSC = {16'd37281, 16'd29829, 16'd22371, 16'd14913, 16'd7457},
  parameter logic [5*CNT_W-1:0] STEPS_PAL  = {16'd41565, 16'd33253, 16'd24939, 16'd16627, 16'd8313}
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] apu_addr,
  input  logic [7:0] data_in,
  input  logic       apu_rd,
  input  logic       apu_wr,
  input  logic       pal,
  output logic       apu_cycle,
  output logic       qtrframe,
  output logic       halfframe,
  output logic       irq,
  output logic       status_irq,
  output logic [2:0] step
);

  localparam logic [CNT_W-1:0] C_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] r_cnt;
  logic             r_apu_cycle, r_mode, r_inhibit, r_irq, r_pal;
  logic             r_forced, r_after_t4, r_pend;
  logic [1:0]       r_dly;
  logic [2:0]       r_step;

  logic [5*CNT_W-1:0] w_tbl;
  logic [CNT_W-1:0]   w_t1, w_t2, w_t3, w_t4, w_t5, w_t4m1;
  logic w_hit1, w_hit2, w_hit3, w_hit4, w_hit5;
  logic w_wr4017, w_rd4015, w_wrap, w_fire, w_load0, w_irq_set, w_irq_kill, w_step_pt;
  logic w_unused;

  assign w_tbl  = r_pal ? STEPS_PAL : STEPS_NTSC;
  assign w_t1   = w_tbl[CNT_W-1:0];
  assign w_t2   = w_tbl[2*CNT_W-1:CNT_W];
  assign w_t3   = w_tbl[3*CNT_W-1:2*CNT_W];
  assign w_t4   = w_tbl[4*CNT_W-1:3*CNT_W];
  assign w_t5   = w_tbl[5*CNT_W-1:4*CNT_W];
  assign w_t4m1 = w_t4 - C_ONE;

  assign w_hit1 = (r_cnt == w_t1);
  assign w_hit2 = (r_cnt == w_t2);
  assign w_hit3 = (r_cnt == w_t3);
  assign w_hit4 = (r_cnt == w_t4);
  assign w_hit5 = (r_cnt == w_t5);

  // apu_rd/apu_wr are single-cycle strobes qualified by apu_addr; no back-pressure.
  assign w_wr4017 = apu_wr && (apu_addr == 5'h17);
  assign w_rd4015 = apu_rd && (apu_addr == 5'h15);

  // A write landing on the firing cycle re-arms instead of firing the old reset.
  assign w_wrap  = r_mode ? w_hit5 : w_hit4;
  assign w_fire  = r_pend && (r_dly == 2'd1) && !w_wr4017;
  assign w_load0 = w_wrap || w_fire;

  assign w_irq_set  = !r_mode && !r_inhibit &&
                      ((r_cnt == w_t4m1) || w_hit4 || ((r_cnt == '0) && r_after_t4));
  assign w_irq_kill = r_inhibit || (w_wr4017 && data_in[6]);
  assign w_step_pt  = w_hit1 || w_hit2 || w_hit3 || (w_hit4 && r_mode);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_apu_cycle <= 1'b1;
      r_mode      <= 1'b0;
      r_inhibit   <= 1'b0;
      r_irq       <= 1'b0;
      r_pal       <= pal;
      r_forced    <= 1'b0;
      r_after_t4  <= 1'b0;
      r_pend      <= 1'b0;
      r_dly       <= 2'd0;
      r_step      <= 3'd0;
    end else begin
      r_apu_cycle <= ~r_apu_cycle;
      r_cnt       <= w_load0 ? '0 : r_cnt + C_ONE;
      r_step      <= w_load0 ? 3'd0 : (w_step_pt ? r_step + 3'd1 : r_step);
      if (w_load0) r_pal <= pal;
      // A reset merged with a natural wrap must not add a second pulse pair.
      r_forced    <= w_fire && !w_wrap;
      r_after_t4  <= !r_mode && w_hit4;

      if (w_wr4017) begin
        r_mode    <= data_in[7];
        r_inhibit <= data_in[6];
        r_pend    <= 1'b1;
        r_dly     <= r_apu_cycle ? 2'd2 : 2'd3;
      end else if (r_pend) begin
        if (r_dly == 2'd1) r_pend <= 1'b0;
        else               r_dly  <= r_dly - 2'd1;
      end

      if (w_irq_kill)     r_irq <= 1'b0;
      else if (w_irq_set) r_irq <= 1'b1;
      else if (w_rd4015)  r_irq <= 1'b0;
    end
  end

  assign apu_cycle  = r_apu_cycle;
  assign qtrframe   = r_mode ? (w_hit1 || w_hit2 || w_hit3 || w_hit5 || r_forced)
                             : (w_hit1 || w_hit2 || w_hit3 || w_hit4);
  assign halfframe  = r_mode ? (w_hit2 || w_hit5 || r_forced) : (w_hit2 || w_hit4);
  assign irq        = r_irq;
  assign status_irq = r_irq;
  assign step       = r_step;
  assign w_unused   = ^data_in[5:0];

endmodule

// File: doc/apu_frame_sequencer.md
# apu_frame_sequencer

Parametrised APU frame sequencer: the CPU-clock-domain block that produces the APU half-rate tick, quarter-frame and half-frame clock pulses for envelopes, length counters and sweeps, and the frame IRQ. It supersedes the fixed NTSC frame counter and adds the following:
- selectable NTSC/PAL step tables;
- the hardware-accurate 3/4-cycle delay on $4017 writes;
- a readable IRQ status bit for $4015;
- a step-index debug output.

It sits beside the APU register decode and drives all channel units.

## Interface
Parameters:
- CNT_W, 16: frame counter width; must hold the largest step value.
- STEPS_NTSC, {16'd37281,16'd29829,16'd22371,16'd14913,16'd7457}: packed 5×CNT_W step table, T5..T1 from MSB to LSB.
- STEPS_PAL, {16'd41565,16'd33253,16'd24939,16'd16627,16'd8313}: PAL step table, same packing.

Ports:
- clk  in  1  CPU clock.
- rst  in  1  synchronous, active-high reset.
- apu_addr  in  5  APU register offset.
- data_in  in  8  write data.
- apu_rd  in  1  single-cycle read strobe.
- apu_wr  in  1  single-cycle write strobe.
- pal  in  1  region select: 1 selects STEPS_PAL.
- apu_cycle  out  1  APU half-rate phase; toggles every clk.
- qtrframe  out  1  one-cycle quarter-frame pulse.
- halfframe  out  1  one-cycle half-frame pulse.
- irq  out  1  frame IRQ flag; level output.
- status_irq  out  1  equals irq; feeds $4015 read data bit 6.
- step  out  3  current step index 0..4.

## Operation
- Counter `cnt` increments by 1 every clk.
- Table T1..T5 comes from the registered region `reg_pal`.
- `reg_pal` loads from `pal` only when `cnt` loads 0, so the step table never changes mid-sequence.
- Mode 0 (4-step) pulse rules:
  - `cnt`==T1 or T3: qtrframe only.
  - `cnt`==T2: qtrframe and halfframe.
  - `cnt`==T4: qtrframe and halfframe; `cnt` loads 0 on the next edge.
- Mode 1 (5-step) pulse rules:
  - T1, T3: qtrframe only.
  - T2, T5: qtrframe and halfframe.
  - T4: no pulse.
  - T5: `cnt` loads 0 on the next edge.
- `step` counts pulse points already passed in the current sequence. It resets to 0 when `cnt` loads 0.
- IRQ set:
  - Applies in mode 0 with inhibit=0.
  - The flag is set on three consecutive cycles: `cnt`==T4−1, `cnt`==T4, and the following `cnt`==0.
- IRQ clear and priority:
  - A $4015 read (`apu_addr`==5'h15 && `apu_rd`) clears the flag, unless a set condition is true in that same cycle; set wins.
  - inhibit=1 forces the flag to 0 every cycle, overriding both set and read.
- $4017 write (`apu_addr`==5'h17 && `apu_wr`):
  - mode ← data_in[7] and inhibit ← data_in[6] on the next edge.
  - Arms a pending reset with delay D: D=3 if `apu_cycle`==1 in the write cycle, otherwise D=4.
  - `cnt` reads 0 exactly D cycles after the write cycle.
  - If the new mode is 1, qtrframe and halfframe both pulse in that same `cnt`==0 cycle.
- A second $4017 write while a reset is pending re-arms the delay from the new write and discards the old one.
- If a natural wrap and the pending reset coincide, `cnt` loads 0 once and the pulses are not doubled.

## Timing
- Values after rst: `cnt`=0, `apu_cycle`=1, mode=0, inhibit=0, irq=0, `reg_pal` ← `pal`, `step`=0, no pending reset, qtrframe=halfframe=0.
- Pulses are combinational decodes of registered state, one cycle wide, and valid in the cycle `cnt` equals the step value.
- irq/status_irq change on the edge after the set or clear condition.
- rst asserted mid-sequence or during a pending reset aborts everything and returns all state to the reset values on the next edge.
- `cnt` never exceeds T5 in mode 1, or T4 in mode 0.
- A mode 1→0 write that lands when `cnt` > T4 is safe, because that write resets `cnt`.

## Test plan
- Reset, NTSC, mode 0, free-run 30000 cycles:
  - qtrframe at `cnt` 7457, 14913, 22371, 29829.
  - halfframe at 14913 and 29829.
  - irq rises after `cnt`=29828 and stays high.
  - wrap to 0 after 29829.
- Mode 0 IRQ, then $4015 read with the set condition absent and again during `cnt`=T4 → flag clears on the first read and stays set on the coincident read.
- $4017 write data 8'h80:
  - write with `apu_cycle`=1: `cnt`=0 three cycles later.
  - write with `apu_cycle`=0: four cycles later.
  - both cases: immediate qtrframe+halfframe pulse, no pulse at T4, halfframe at 37281, no irq.
- $4017 write data 8'h40 with irq=1 → irq=0 next cycle; no irq at T4 thereafter.
- Toggle `pal` mid-sequence → the current sequence keeps NTSC values; the next sequence uses 8313/16627/24939/33253.
- Two $4017 writes two cycles apart, then rst asserted mid-delay:
  - only the second write's delay applies.
  - rst returns all outputs to their reset values.
